// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter that sequences one read/write at a time
// onto a single-port valid/ready memory, returns a per-port done pulse with
// read data, and aborts a memory access that exceeds a timeout.
`timescale 1ns/1ps

module mem_rr_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Port A
  input  logic                  a_valid_i,
  input  logic                  a_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0]      a_wdata_i,
  output logic                  a_ready_o,
  output logic [WIDTH-1:0]      a_rdata_o,
  output logic                  a_err_o,
  // Port B
  input  logic                  b_valid_i,
  input  logic                  b_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0]      b_wdata_i,
  output logic                  b_ready_o,
  output logic [WIDTH-1:0]      b_rdata_o,
  output logic                  b_err_o,
  // Memory side
  output logic                  m_valid_o,
  output logic                  m_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WIDTH-1:0]      m_wdata_o,
  input  logic                  m_ready_i,
  input  logic [WIDTH-1:0]      m_rdata_i,
  output logic                  busy_o
);

  localparam int                TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    grant_a;
  logic                    grant_b;
  logic                    mem_done;
  logic                    mem_abort;
  logic                    last_grant_b_q;
  logic                    sel_b_q;
  logic                    cmd_wr_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [WIDTH-1:0]        cmd_wdata_q;
  logic [TMR_W-1:0]        timer_q;

  assign m_wr_rd_o = cmd_wr_q;
  assign m_addr_o  = cmd_addr_q;
  assign m_wdata_o = cmd_wdata_q;
  assign busy_o    = (state_q != IDLE);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: arbitration in IDLE, completion/timeout detection in ISSUE
  always_comb begin
    state_d   = state_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    mem_done  = 1'b0;
    mem_abort = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first
        if (a_valid_i && (!b_valid_i || last_grant_b_q)) begin
          grant_a = 1'b1;
        end else if (b_valid_i) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) state_d = ISSUE;
      end
      ISSUE: begin
        if (m_ready_i) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end else if (timer_q == TMR_LAST) begin
          mem_abort = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture on grant so the memory sees a stable request
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_b_q <= 1'b1;
      sel_b_q        <= 1'b0;
      cmd_wr_q       <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
    end else if (grant_a) begin
      last_grant_b_q <= 1'b0;
      sel_b_q        <= 1'b0;
      cmd_wr_q       <= a_wr_rd_i;
      cmd_addr_q     <= a_addr_i;
      cmd_wdata_q    <= a_wdata_i;
    end else if (grant_b) begin
      last_grant_b_q <= 1'b1;
      sel_b_q        <= 1'b1;
      cmd_wr_q       <= b_wr_rd_i;
      cmd_addr_q     <= b_addr_i;
      cmd_wdata_q    <= b_wdata_i;
    end
  end

  // Memory wait timer, cleared on grant and counting each unanswered ISSUE cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      timer_q <= '0;
    end else if (grant_a || grant_b) begin
      timer_q <= '0;
    end else if ((state_q == ISSUE) && !mem_done && !mem_abort) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Memory request strobe, raised on grant and dropped after completion or abort
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_o <= 1'b0;
    end else if (grant_a || grant_b) begin
      m_valid_o <= 1'b1;
    end else if (mem_done || mem_abort) begin
      m_valid_o <= 1'b0;
    end
  end

  // Per-port response: one-cycle done pulse, error flag, and held read data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_ready_o <= 1'b0;
      a_err_o   <= 1'b0;
      a_rdata_o <= '0;
      b_ready_o <= 1'b0;
      b_err_o   <= 1'b0;
      b_rdata_o <= '0;
    end else begin
      a_ready_o <= 1'b0;
      a_err_o   <= 1'b0;
      b_ready_o <= 1'b0;
      b_err_o   <= 1'b0;
      if (mem_done || mem_abort) begin
        if (sel_b_q) begin
          b_ready_o <= 1'b1;
          b_err_o   <= mem_abort;
          if (mem_done && !cmd_wr_q) b_rdata_o <= m_rdata_i;
        end else begin
          a_ready_o <= 1'b1;
          a_err_o   <= mem_abort;
          if (mem_done && !cmd_wr_q) a_rdata_o <= m_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: a transaction-level model predicts the
// grant order, read data and error flags; a memory responder with random
// latency sits on the memory port; a monitor checks every done pulse.
`timescale 1ns/1ps

module tb_mem_rr_arbiter;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          a_valid_i, a_wr_rd_i, a_ready_o, a_err_o;
  logic [AW-1:0] a_addr_i;
  logic [W-1:0]  a_wdata_i, a_rdata_o;
  logic          b_valid_i, b_wr_rd_i, b_ready_o, b_err_o;
  logic [AW-1:0] b_addr_i;
  logic [W-1:0]  b_wdata_i, b_rdata_o;
  logic          m_valid_o, m_wr_rd_o, m_ready_i, busy_o;
  logic [AW-1:0] m_addr_o;
  logic [W-1:0]  m_wdata_o, m_rdata_i;

  mem_rr_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_wr_rd_i(a_wr_rd_i), .a_addr_i(a_addr_i),
    .a_wdata_i(a_wdata_i), .a_ready_o(a_ready_o), .a_rdata_o(a_rdata_o),
    .a_err_o(a_err_o),
    .b_valid_i(b_valid_i), .b_wr_rd_i(b_wr_rd_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o),
    .b_err_o(b_err_o),
    .m_valid_o(m_valid_o), .m_wr_rd_o(m_wr_rd_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_ready_i(m_ready_i), .m_rdata_i(m_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           port_b;
    bit           err;
    logic [W-1:0] rdata;
  } exp_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } mcmd_t;

  exp_t  exp_q[$];
  mcmd_t mem_q[$];

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit           m_last_b;
  logic [W-1:0] m_rdata [2];
  logic [W-1:0] shadow  [16];

  // memory responder controls
  int lat_fixed = 0;
  bit hang      = 1'b0;
  int last_burst = 0;

  function automatic logic [W-1:0] init_val(input int i);
    return 16'hA5A5 ^ W'(i * 16'h0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a_ready"}, a_ready_o, 0);
    chk({tag, "_b_ready"}, b_ready_o, 0);
    chk({tag, "_a_err"},   a_err_o,   0);
    chk({tag, "_b_err"},   b_err_o,   0);
    chk({tag, "_a_rdata"}, a_rdata_o, 0);
    chk({tag, "_b_rdata"}, b_rdata_o, 0);
    chk({tag, "_m_valid"}, m_valid_o, 0);
    chk({tag, "_m_wr_rd"}, m_wr_rd_o, 0);
    chk({tag, "_m_addr"},  m_addr_o,  0);
    chk({tag, "_m_wdata"}, m_wdata_o, 0);
    chk({tag, "_busy"},    busy_o,    0);
  endtask

  // Model of one serviced request: memory effect, held read data, error.
  task automatic push_txn(input bit pb, input bit wr, input logic [AW-1:0] addr,
                          input logic [W-1:0] d);
    exp_t  e;
    mcmd_t mc;
    e.port_b = pb;
    if (hang) begin
      e.err   = 1'b1;
      e.rdata = m_rdata[pb];
    end else begin
      e.err    = 1'b0;
      mc.wr    = wr;
      mc.addr  = addr;
      mc.wdata = d;
      mem_q.push_back(mc);
      if (wr) shadow[addr] = d;
      else    m_rdata[pb]  = shadow[addr];
      e.rdata = m_rdata[pb];
    end
    exp_q.push_back(e);
  endtask

  // Present requests, predict service order, release each port after its done pulse.
  task automatic run_round(input bit ae, input bit aw, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                           input bit be, input bit bw, input logic [AW-1:0] ba, input logic [W-1:0] bd,
                           input bit drop);
    int pending;
    int cyc;
    @(negedge clk_i);
    chk("idle_before_round", busy_o, 0);
    a_valid_i = ae; a_wr_rd_i = aw; a_addr_i = aa; a_wdata_i = ad;
    b_valid_i = be; b_wr_rd_i = bw; b_addr_i = ba; b_wdata_i = bd;
    if (ae && be) begin
      if (m_last_b) begin
        push_txn(1'b0, aw, aa, ad); push_txn(1'b1, bw, ba, bd); m_last_b = 1'b1;
      end else begin
        push_txn(1'b1, bw, ba, bd); push_txn(1'b0, aw, aa, ad); m_last_b = 1'b0;
      end
    end else if (ae) begin
      push_txn(1'b0, aw, aa, ad); m_last_b = 1'b0;
    end else if (be) begin
      push_txn(1'b1, bw, ba, bd); m_last_b = 1'b1;
    end
    pending = int'(ae) + int'(be);
    cyc = 0;
    while (pending > 0 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (a_ready_o) begin a_valid_i = 1'b0; pending--; end
      if (b_ready_o) begin b_valid_i = 1'b0; pending--; end
      if (drop && cyc == 2 && !(ae && be)) begin
        a_valid_i = 1'b0; a_wr_rd_i = 1'($urandom); a_addr_i = AW'($urandom); a_wdata_i = W'($urandom);
        b_valid_i = 1'b0; b_wr_rd_i = 1'($urandom); b_addr_i = AW'($urandom); b_wdata_i = W'($urandom);
      end
    end
    if (pending > 0) begin
      n_vec++; n_err++;
      $display("FAIL round_timeout: %0d responses outstanding, required 0", pending);
      a_valid_i = 1'b0; b_valid_i = 1'b0;
    end
  endtask

  // Memory responder: answers after lat cycles of m_valid_o, or never when hang is set.
  initial begin : mem_model
    logic [W-1:0] mem [16];
    int cnt;
    int lat;
    mcmd_t mc;
    for (int i = 0; i < 16; i++) mem[i] = init_val(i);
    cnt = 0; lat = 1;
    m_ready_i = 1'b0; m_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      m_ready_i = 1'b0;
      m_rdata_i = W'($urandom);
      if (!rst_i || !m_valid_o) begin
        if (cnt != 0) last_burst = cnt;
        cnt = 0;
      end else begin
        if (cnt == 0) lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        cnt++;
        if (!hang && cnt == lat) begin
          if (mem_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mem_unexpected: memory request addr %0h with no expected command", m_addr_o);
          end else begin
            mc = mem_q.pop_front();
            chk("mem_wr_rd", m_wr_rd_o, mc.wr);
            chk("mem_addr",  m_addr_o,  mc.addr);
            if (mc.wr) chk("mem_wdata", m_wdata_o, mc.wdata);
          end
          if (m_wr_rd_o) mem[m_addr_o] = m_wdata_o;
          else           m_rdata_i = mem[m_addr_o];
          m_ready_i = 1'b1;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the next predicted response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1 && (a_ready_o || b_ready_o)) begin
        chk("single_ready", a_ready_o & b_ready_o, 0);
        chk("busy_in_resp", busy_o, 1);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL ready_unexpected: a_ready=%0b b_ready=%0b with no expected response", a_ready_o, b_ready_o);
        end else begin
          e = exp_q.pop_front();
          chk("ready_port_b", b_ready_o, e.port_b);
          if (e.port_b) begin
            chk("b_err", b_err_o, e.err);
            chk("b_rdata", b_rdata_o, e.rdata);
          end else begin
            chk("a_err", a_err_o, e.err);
            chk("a_rdata", a_rdata_o, e.rdata);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int cyc;
    logic [W-1:0] wd [16];
    bit ae, be, drop;
    rst_i = 1'b0;
    a_valid_i = 0; a_wr_rd_i = 0; a_addr_i = '0; a_wdata_i = '0;
    b_valid_i = 0; b_wr_rd_i = 0; b_addr_i = '0; b_wdata_i = '0;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    m_last_b = 1'b1;
    m_rdata[0] = '0; m_rdata[1] = '0;

    // reset with random inputs
    repeat (2) begin
      a_valid_i = 1'($urandom); a_wr_rd_i = 1'($urandom); a_addr_i = AW'($urandom); a_wdata_i = W'($urandom);
      b_valid_i = 1'($urandom); b_wr_rd_i = 1'($urandom); b_addr_i = AW'($urandom); b_wdata_i = W'($urandom);
      @(negedge clk_i);
      chk_reset_outs("rst");
    end
    a_valid_i = 0; b_valid_i = 0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_m_valid", m_valid_o, 0);

    // A write 3 <- BEEF with memory latency 2, then B write 5 <- 1234
    lat_fixed = 2;
    run_round(1, 1, 4'd3, 16'hBEEF, 0, 0, 4'd0, 16'h0, 0);
    lat_fixed = 0;
    run_round(0, 0, 4'd0, 16'h0, 1, 1, 4'd5, 16'h1234, 0);

    // simultaneous reads, twice: A first each time
    run_round(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);
    run_round(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);

    // memory never answers: B read aborts after TO cycles, then normal service
    hang = 1'b1;
    run_round(0, 0, 4'd0, 16'h0, 1, 0, 4'd7, 16'h0, 0);
    hang = 1'b0;
    @(negedge clk_i);
    chk("timeout_m_valid_cycles", 32'(last_burst), TO);
    run_round(0, 0, 4'd0, 16'h0, 1, 0, 4'd5, 16'h0, 0);

    // reset while the memory request is outstanding
    hang = 1'b1;
    @(negedge clk_i);
    a_valid_i = 1; a_wr_rd_i = 1; a_addr_i = 4'd9; a_wdata_i = W'($urandom);
    cyc = 0;
    while (!m_valid_o && cyc < 20) begin @(negedge clk_i); cyc++; end
    chk("rst5_m_valid_seen", m_valid_o, 1);
    @(negedge clk_i);
    a_valid_i = 0;
    #2 rst_i = 1'b0;
    #1;
    chk("rst5_m_valid_drop", m_valid_o, 0);
    chk("rst5_busy", busy_o, 0);
    chk("rst5_a_ready", a_ready_o, 0);
    m_last_b = 1'b1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    hang = 1'b0;
    @(negedge clk_i);
    chk_reset_outs("rst5");
    rst_i = 1'b1;
    run_round(1, 0, 4'd3, 16'h0, 1, 0, 4'd5, 16'h0, 0);

    // fill all addresses from A, read back through B, random latency
    for (int i = 0; i < 16; i++) begin
      wd[i] = W'($urandom);
      run_round(1, 1, AW'(i), wd[i], 0, 0, 4'd0, 16'h0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      run_round(0, 0, 4'd0, 16'h0, 1, 0, AW'(i), 16'h0, 0);
      chk("readback", b_rdata_o, wd[i]);
    end

    // random traffic: mixed ports, ops, early valid drop, occasional timeout
    repeat (40) begin
      ae = 1'($urandom); be = 1'($urandom);
      if (!ae && !be) ae = 1'b1;
      drop = ($urandom_range(0, 3) == 0);
      hang = ($urandom_range(0, 7) == 0);
      run_round(ae, 1'($urandom), AW'($urandom), W'($urandom),
                be, 1'($urandom), AW'($urandom), W'($urandom), drop);
      hang = 1'b0;
    end

    repeat (5) @(negedge clk_i);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
